// File: rtl/multicycle_control_unit.sv
// ============================================================================
// Module      : multicycle_control_unit
// Description : Moore main-control FSM for a multicycle RV32I datapath with a
//               shared instruction/data memory, a memory-ready handshake with
//               a timeout, and sticky illegal-opcode / bus-error flags.
//               Define MC_JAL_EN to add the JAL sequence (DECODE -> JAL -> ALUWB).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_unit #(
  parameter int ALU_OP_W    = 2,
  parameter int STATE_W     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                adr_src,
  output logic                mem_req,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal_op,
  output logic                bus_err,
  output logic [STATE_W-1:0]  dbg_state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECR    = STATE_W'(6),
    S_ALUWB    = STATE_W'(7),
    S_EXECI    = STATE_W'(8),
    S_BEQ      = STATE_W'(9),
    S_JAL      = STATE_W'(10)
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(2'b00);
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(2'b01);
  localparam logic [ALU_OP_W-1:0] ALU_RFUNC = ALU_OP_W'(2'b10);
  localparam logic [ALU_OP_W-1:0] ALU_IFUNC = ALU_OP_W'(2'b11);

  localparam int               CNT_W       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  logic pc_update;
  logic branch;
  logic wait_state;
  logic timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Next state, wait counter and sticky flags
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;

    wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    timeout    = (MEM_TIMEOUT != 0) && wait_state && !mem_ready && (wait_cnt_q == TIMEOUT_VAL);

    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BEQ:            state_d = S_BEQ;
`ifdef MC_JAL_EN
          OP_JAL:            state_d = S_JAL;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase

    // A timeout in FETCH is not a state change, so the counter is cleared explicitly
    if (timeout) begin
      state_d    = S_FETCH;
      bus_err_d  = 1'b1;
      wait_cnt_d = '0;
    end else if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (wait_state && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Moore output decode; only FETCH and BEQ look at inputs
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_RFUNC;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALU_IFUNC;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
      end
`ifdef MC_JAL_EN
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
`endif
      default: ;
    endcase

    pc_write = pc_update | (branch & zero);
  end

  assign illegal_op = illegal_q;
  assign bus_err    = bus_err_q;
  assign dbg_state  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: the driver queues the expected
// control word for every cycle, a monitor compares on the falling edge.
`default_nettype none

module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_req, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       illegal_op, bus_err;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .bus_err    (bus_err),
    .dbg_state  (dbg_state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mreq, mwr, irw, rw;
    logic [1:0] rs, sa, sb, op;
    logic       ill, be;
  } ctrl_t;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BAD  = 7'b1111111;

  ctrl_t exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  // Expected control word for a state, straight from the state output table
  function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic mr, input logic z,
                                     input logic ill, input logic be);
    ctrl_t c;
    c     = '0;
    c.st  = st;
    c.ill = ill;
    c.be  = be;
    case (st)
      4'd0:  begin c.mreq = 1; c.sb = 2'b10; c.rs = 2'b10; c.irw = mr; c.pcw = mr; end
      4'd1:  begin c.sa = 2'b01; c.sb = 2'b01; end
      4'd2:  begin c.sa = 2'b10; c.sb = 2'b01; end
      4'd3:  begin c.mreq = 1; c.adr = 1; end
      4'd4:  begin c.rs = 2'b01; c.rw = 1; end
      4'd5:  begin c.mreq = 1; c.mwr = 1; c.adr = 1; end
      4'd6:  begin c.sa = 2'b10; c.op = 2'b10; end
      4'd7:  begin c.rw = 1; end
      4'd8:  begin c.sa = 2'b10; c.sb = 2'b01; c.op = 2'b11; end
      4'd9:  begin c.sa = 2'b10; c.op = 2'b01; c.pcw = z; end
      4'd10: begin c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1; end
      default: ;
    endcase
    return c;
  endfunction

  // Drive one cycle of inputs and queue the expected outputs for that cycle
  task automatic cyc(input logic [6:0] opc, input logic mr, input logic z,
                     input logic [3:0] st, input logic ill, input logic be, input string nm);
    opcode    = opc;
    mem_ready = mr;
    zero      = z;
    exp_q.push_back(exp_ctrl(st, mr, z, ill, be));
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctrl_t e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {dbg_state, pc_write, adr_src, mem_req, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, illegal_op, bus_err};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got %05h required %05h (state got %0d req %0d)", n, a, e, a.st, e.st);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic ji;

  initial begin
    reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    cyc(7'h00, 0, 0, 4'd0, 0, 0, "reset_state");
    reset = 1'b0;

    // lw with memory always ready
    cyc(LW, 1, 0, 4'd0, 0, 0, "lw_fetch");
    cyc(LW, 1, 0, 4'd1, 0, 0, "lw_decode");
    cyc(LW, 1, 0, 4'd2, 0, 0, "lw_memadr");
    cyc(LW, 1, 0, 4'd3, 0, 0, "lw_memread");
    cyc(LW, 1, 0, 4'd4, 0, 0, "lw_memwb");

    // sw with three wait cycles in MEMWRITE
    cyc(SW, 1, 0, 4'd0, 0, 0, "sw_fetch");
    cyc(SW, 1, 0, 4'd1, 0, 0, "sw_decode");
    cyc(SW, 1, 0, 4'd2, 0, 0, "sw_memadr");
    for (int i = 0; i < 3; i++) cyc(SW, 0, 0, 4'd5, 0, 0, "sw_memwrite_wait");
    cyc(SW, 1, 0, 4'd5, 0, 0, "sw_memwrite_done");

    // beq taken then not taken
    cyc(BEQ, 1, 1, 4'd0, 0, 0, "beq1_fetch");
    cyc(BEQ, 1, 1, 4'd1, 0, 0, "beq1_decode");
    cyc(BEQ, 1, 1, 4'd9, 0, 0, "beq_taken");
    cyc(BEQ, 1, 0, 4'd0, 0, 0, "beq0_fetch");
    cyc(BEQ, 1, 0, 4'd1, 0, 0, "beq0_decode");
    cyc(BEQ, 1, 0, 4'd9, 0, 0, "beq_not_taken");

    // R-type then I-type
    cyc(RT, 1, 0, 4'd0, 0, 0, "r_fetch");
    cyc(RT, 1, 0, 4'd1, 0, 0, "r_decode");
    cyc(RT, 1, 0, 4'd6, 0, 0, "r_execr");
    cyc(RT, 1, 0, 4'd7, 0, 0, "r_aluwb");
    cyc(IT, 1, 0, 4'd0, 0, 0, "i_fetch");
    cyc(IT, 1, 0, 4'd1, 0, 0, "i_decode");
    cyc(IT, 1, 0, 4'd8, 0, 0, "i_execi");
    cyc(IT, 1, 0, 4'd7, 0, 0, "i_aluwb");

    // JAL: legal only when the feature is built in
    cyc(JAL, 1, 0, 4'd0, 0, 0, "jal_fetch");
    cyc(JAL, 1, 0, 4'd1, 0, 0, "jal_decode");
`ifdef MC_JAL_EN
    cyc(JAL, 1, 0, 4'd10, 0, 0, "jal_jal");
    cyc(JAL, 1, 0, 4'd7, 0, 0, "jal_aluwb");
    ji = 1'b0;
`else
    ji = 1'b1;
`endif

    // Unsupported opcode sets the sticky flag after DECODE
    cyc(BAD, 1, 0, 4'd0, ji, 0, "bad_fetch");
    cyc(BAD, 1, 0, 4'd1, ji, 0, "bad_decode");
    cyc(IT, 1, 0, 4'd0, 1, 0, "bad_back_fetch");
    cyc(IT, 1, 0, 4'd1, 1, 0, "illegal_sticky");
    cyc(IT, 1, 0, 4'd8, 1, 0, "post_illegal_execi");
    cyc(IT, 1, 0, 4'd7, 1, 0, "post_illegal_aluwb");

    // lw whose ready arrives exactly at the timeout cycle: ready wins
    cyc(LW, 1, 0, 4'd0, 1, 0, "lw2_fetch");
    cyc(LW, 1, 0, 4'd1, 1, 0, "lw2_decode");
    cyc(LW, 1, 0, 4'd2, 1, 0, "lw2_memadr");
    for (int i = 0; i < 15; i++) cyc(LW, 0, 0, 4'd3, 1, 0, "lw2_memread_wait");
    cyc(LW, 1, 0, 4'd3, 1, 0, "lw2_ready_at_timeout");
    cyc(LW, 1, 0, 4'd4, 1, 0, "lw2_memwb_no_buserr");

    // FETCH timeout: 16 wait cycles then abort with bus_err
    for (int i = 0; i < 16; i++) cyc(LW, 0, 0, 4'd0, 1, 0, "fetch_wait");
    cyc(LW, 0, 0, 4'd0, 1, 1, "fetch_timeout_buserr");
    cyc(LW, 0, 0, 4'd0, 1, 1, "fetch_restart_wait");
    cyc(LW, 1, 0, 4'd0, 1, 1, "fetch_recover");
    cyc(LW, 1, 0, 4'd1, 1, 1, "recover_decode");
    cyc(LW, 1, 0, 4'd2, 1, 1, "recover_memadr");
    cyc(LW, 1, 0, 4'd3, 1, 1, "recover_memread");

    // Reset rising during MEMWB suppresses the write and clears the flags
    reset = 1'b1;
    cyc(LW, 0, 0, 4'd0, 0, 0, "reset_mid_instr");
    reset = 1'b0;
    cyc(LW, 1, 0, 4'd0, 0, 0, "after_reset_fetch");

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
